// File: rtl/f3m_sub_serial_pkg.sv
// Shared definitions for the serial GF(3^M) subtractor: field size macros,
// digit codes and FSM state encoding.
`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif

package f3m_sub_serial_pkg;

    // Field extension degree and packed operand width (2 bits per digit)
    localparam int unsigned M_DIGITS = `M;
    localparam int unsigned DATA_W   = `WIDTH + 1;

    // GF(3) digit codes; 2'b11 is not a valid digit
    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/f3m_sub_serial_f3_sub.sv
// Single GF(3) digit subtractor: c = (a - b) mod 3, computed as a + neg(b).
// With F3M_SUB_ADD_MODE_EN defined, add_mode=1 skips the negation (c = a + b).
// Invalid code 2'b11 on either input forces c to zero.
module f3_sub
    import f3m_sub_serial_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
`ifdef F3M_SUB_ADD_MODE_EN
    input  logic       add_mode,
`endif
    output logic [1:0] c
);

    logic [1:0] b_eff;
    logic [2:0] sum;

    // Negate by swapping the code bits, then add and reduce mod 3
    always_comb begin
        b_eff = {b[0], b[1]};
`ifdef F3M_SUB_ADD_MODE_EN
        if (add_mode) begin
            b_eff = b;
        end
`endif
        sum = {1'b0, a} + {1'b0, b_eff};
        if ((a == 2'b11) || (b == 2'b11)) begin
            c = F3_ZERO;
        end else if (sum >= 3'd3) begin
            c = 2'(sum - 3'd3);
        end else begin
            c = sum[1:0];
        end
    end

endmodule

// File: rtl/f3m_sub_serial.sv
// Sequential GF(3^M) subtractor C = A - B, DPC digits per cycle under a
// start/busy/done handshake. Optional macro F3M_SUB_ADD_MODE_EN adds an
// op input selecting A+B (op=1) instead of A-B.
module f3m_sub_serial
    import f3m_sub_serial_pkg::*;
#(
    parameter int unsigned DPC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
`ifdef F3M_SUB_ADD_MODE_EN
    input  logic              op,
`endif
    output logic [DATA_W-1:0] C,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CHUNK_W    = 2 * DPC;
    localparam int unsigned NCYC       = (M_DIGITS + DPC - 1) / DPC;
    localparam int unsigned PAD_W      = NCYC * CHUNK_W;
    localparam int unsigned CNT_W      = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int unsigned CHUNK_IX_W = $clog2(CHUNK_W);
    localparam int unsigned DATA_IX_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 load;
    logic                 step;
    logic [PAD_W-1:0]     a_sr;
    logic [PAD_W-1:0]     b_sr;
    logic [CNT_W-1:0]     cnt;
    logic [CHUNK_W-1:0]   chunk_c;
    logic [DATA_W-1:0]    c_nxt_c;
`ifdef F3M_SUB_ADD_MODE_EN
    logic                 op_r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered status flags, decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Operand capture (zero-padded to whole chunks), shifting and chunk counter
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr <= '0;
            b_sr <= '0;
            cnt  <= '0;
`ifdef F3M_SUB_ADD_MODE_EN
            op_r <= 1'b0;
`endif
        end else if (load) begin
            a_sr <= PAD_W'(A);
            b_sr <= PAD_W'(B);
            cnt  <= '0;
`ifdef F3M_SUB_ADD_MODE_EN
            op_r <= op;
`endif
        end else if (step) begin
            a_sr <= a_sr >> CHUNK_W;
            b_sr <= b_sr >> CHUNK_W;
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // DPC parallel digit subtractors on the low chunk of the shift registers
    for (genvar g = 0; g < int'(DPC); g++) begin : g_digit
        f3_sub u_f3_sub (
            .a        (a_sr[2*g +: 2]),
            .b        (b_sr[2*g +: 2]),
`ifdef F3M_SUB_ADD_MODE_EN
            .add_mode (op_r),
`endif
            .c        (chunk_c[2*g +: 2])
        );
    end

    // Merge current chunk into C; chunk 0 starts from zero, padding digits are dropped
    always_comb begin
        c_nxt_c = (cnt == '0) ? '0 : C;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if ((i / CHUNK_W) == 32'(cnt)) begin
                c_nxt_c[DATA_IX_W'(i)] = chunk_c[CHUNK_IX_W'(i % CHUNK_W)];
            end
        end
    end

    // Result register, written only while running
    always_ff @(posedge clk) begin
        if (reset) begin
            C <= '0;
        end else if (step) begin
            C <= c_nxt_c;
        end
    end

endmodule

// File: tb/tb_f3m_sub_serial.sv
// Self-checking bench for f3m_sub_serial: a scoreboard queue holds expected
// results pushed at start and popped on each done pulse.
module tb_f3m_sub_serial;
    import f3m_sub_serial_pkg::*;

    localparam int unsigned DW   = DATA_W;
    localparam int unsigned NCYC = (M_DIGITS + 8 - 1) / 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          op_s;
    logic [DW-1:0] C;
    logic          busy;
    logic          done;

    int            n_checks;
    int            n_errors;
    int            n_done;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_v;

    f3m_sub_serial #(.DPC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef F3M_SUB_ADD_MODE_EN
        .op    (op_s),
`endif
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: digit-wise (a -/+ b) mod 3 in integer arithmetic, code 3 -> 0
    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic o);
        logic [DW-1:0] r;
        int da, db, dr;
        r = '0;
        for (int i = 0; i < int'(M_DIGITS); i++) begin
            da = int'(a[2*i +: 2]);
            db = int'(b[2*i +: 2]);
            if (da == 3 || db == 3) dr = 0;
            else if (o) dr = (da + db) % 3;
            else dr = (da + 3 - db) % 3;
            r[2*i +: 2] = 2'(dr);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(M_DIGITS); i++) r[2*i +: 2] = d;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec(input bit allow_bad);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(M_DIGITS); i++) begin
            if (allow_bad && ($urandom_range(0, 15) == 0)) r[2*i +: 2] = 2'b11;
            else r[2*i +: 2] = 2'($urandom_range(0, 2));
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", DW'(1), DW'(0));
            end else begin
                exp_v = sb.pop_front();
                check("result", C, exp_v);
                check("result_no_x", DW'($isunknown(C)), DW'(0));
            end
        end
    end

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic o);
        A     = a;
        B     = b;
        op_s  = o;
        start = 1'b1;
        sb.push_back(model(a, b, o));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < int'(4 * NCYC)) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", DW'(0), DW'(1));
    endtask

    initial begin
        int cyc, bcyc, d0;
        logic [DW-1:0] r;
        n_checks = 0;
        n_errors = 0;
        n_done   = 0;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        op_s  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_c", C, DW'(0));

        // Reset and start together: reset wins
        A = fill(2'b01);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_beats_start", DW'(busy), DW'(0));
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1 - 2 = 2 per digit, latency and busy length
        start_op(fill(2'b01), fill(2'b10), 1'b0);
        wait_done(cyc, bcyc);
        check("t1_latency", DW'(cyc), DW'(NCYC));
        check("t1_busy_cycles", DW'(bcyc), DW'(NCYC));
        check("t1_c", C, {97{2'b10}});
        @(posedge clk);
        #1;
        check("t1_done_pulse", DW'(done), DW'(0));
        check("t1_idle_busy", DW'(busy), DW'(0));

        // A == B gives zero; back-to-back start during DONE
        r = rand_vec(1'b0);
        start_op(r, r, 1'b0);
        wait_done(cyc, bcyc);
        r = rand_vec(1'b0);
        start_op(r, r, 1'b0);
        wait_done(cyc, bcyc);
        check("t2_b2b_latency", DW'(cyc), DW'(NCYC));
        check("t2_b2b_busy", DW'(bcyc), DW'(NCYC));
        check("t2_c_zero", C, DW'(0));
        @(posedge clk);
        #1;

        // Start while busy is ignored, operand changes after capture ignored
        d0 = n_done;
        start_op(fill(2'b10), fill(2'b00), 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        A = fill(2'b00);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcyc);
        check("t3_c", C, fill(2'b10));
        repeat (20) @(posedge clk);
        #1;
        check("t3_one_done", DW'(n_done - d0), DW'(1));

        // Reset in RUN cycle 5 aborts with no done
        start_op(fill(2'b01), fill(2'b00), 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        check("t4_busy", DW'(busy), DW'(0));
        check("t4_done", DW'(done), DW'(0));
        check("t4_c", C, DW'(0));
        d0 = n_done;
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_done", DW'(n_done - d0), DW'(0));

        // Invalid digit code forces that output digit to zero
        r = fill(2'b01);
        r[1:0] = 2'b11;
        start_op(r, fill(2'b01), 1'b0);
        wait_done(cyc, bcyc);
        check("t5_c", C, DW'(0));
        check("t5_no_x", DW'($isunknown(C)), DW'(0));
        @(posedge clk);
        #1;

        // Random operands, including some invalid codes
        for (int k = 0; k < 4; k++) begin
            start_op(rand_vec(1'b1), rand_vec(1'b1), 1'b0);
            wait_done(cyc, bcyc);
            @(posedge clk);
            #1;
        end

`ifdef F3M_SUB_ADD_MODE_EN
        // Add mode: 2 + 2 = 1, and subtract mode on the same operands
        start_op(fill(2'b10), fill(2'b10), 1'b1);
        wait_done(cyc, bcyc);
        check("t6_add", C, fill(2'b01));
        @(posedge clk);
        #1;
        start_op(fill(2'b10), fill(2'b10), 1'b0);
        wait_done(cyc, bcyc);
        check("t6_sub", C, DW'(0));
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", DW'(sb.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
